// File: rtl/rsv_pkg.sv
// rsv_pkg: operation codes, entry layout and default sizing
// shared by the reservation station, its ALU and the bench.
package rsv_pkg;
   localparam int RSV_XLEN  = 32;
   localparam int RSV_DEPTH = 4;

   typedef enum logic [2:0] {
      RSV_ADD,
      RSV_SUB,
      RSV_AND,
      RSV_OR,
      RSV_XOR,
      RSV_SLL,
      RSV_SRL,
      RSV_SLT
   } rsv_op_e;

   typedef struct packed {
      rsv_op_e               op;
      logic [RSV_XLEN-1:0]   rs1;
      logic [RSV_XLEN-1:0]   rs2;
   } rsv_entry_t;
endpackage

// File: rtl/reservation_station_if.sv
// reservation_station_if: dispatch request/ready plus
// result strobe between dispatch and writeback.
interface reservation_station_if #(
   parameter int XLEN = 32
);
   logic            valid_in;
   logic [2:0]      rsv_type;
   logic [XLEN-1:0] rs1;
   logic [XLEN-1:0] rs2;
   logic            ready_out;
   logic            valid_out;
   logic [XLEN-1:0] result;

   modport master (
      output valid_in, rsv_type, rs1, rs2,
      input  ready_out, valid_out, result
   );

   modport slave (
      input  valid_in, rsv_type, rs1, rs2,
      output ready_out, valid_out, result
   );
endinterface

// File: rtl/rsv_alu.sv
// rsv_alu: single-cycle combinational integer unit
// evaluated on the entry being issued.
module rsv_alu
   import rsv_pkg::*;
#(
   parameter int XLEN = RSV_XLEN
) (
   input  rsv_op_e         op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] y
);
   localparam int SW = $clog2(XLEN);

   logic [SW-1:0] sh;
   logic          lt;

   assign sh = b[SW-1:0];
   assign lt = $signed(a) < $signed(b);

   always_comb begin
      y = '0;
      unique case (op)
         RSV_ADD: y = a + b;
         RSV_SUB: y = a - b;
         RSV_AND: y = a & b;
         RSV_OR:  y = a | b;
         RSV_XOR: y = a ^ b;
         RSV_SLL: y = a << sh;
         RSV_SRL: y = a >> sh;
         RSV_SLT: y = {{(XLEN-1){1'b0}}, lt};
      endcase
   end
endmodule

// File: rtl/reservation_station.sv
// reservation_station: in-order entry FIFO feeding one ALU.
// RSV_BYPASS_EN lets a dispatch into an empty station skip storage.
module reservation_station
   import rsv_pkg::*;
#(
   parameter int XLEN  = RSV_XLEN,
   parameter int DEPTH = RSV_DEPTH
) (
   input logic                  clk,
   input logic                  rst,
   reservation_station_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef struct packed {
      rsv_op_e         op;
      logic [XLEN-1:0] rs1;
      logic [XLEN-1:0] rs2;
   } ent_t;

   ent_t            mem [DEPTH];
   ent_t            in_ent;
   ent_t            alu_ent;
   logic [AW-1:0]   head;
   logic [AW-1:0]   tail;
   logic [CW-1:0]   count;
   logic            push;
   logic            pop;
   logic            byp;
   logic            enq;
   logic [XLEN-1:0] alu_y;
   logic            vld_q;
   logic [XLEN-1:0] res_q;

   assign in_ent = '{
      op:  rsv_op_e'(bus.rsv_type),
      rs1: bus.rs1,
      rs2: bus.rs2
   };

   assign bus.ready_out = count < FULL;
   assign bus.valid_out = vld_q;
   assign bus.result    = res_q;

   assign push = bus.valid_in & bus.ready_out;
   assign pop  = count != '0;

`ifdef RSV_BYPASS_EN
   assign byp = push & ~pop;
`else
   assign byp = 1'b0;
`endif

   // a bypassed entry never touches the array or the count
   assign enq     = push & ~byp;
   assign alu_ent = byp ? in_ent : mem[head];

   rsv_alu #(
      .XLEN (XLEN)
   ) u_alu (
      .op (alu_ent.op),
      .a  (alu_ent.rs1),
      .b  (alu_ent.rs2),
      .y  (alu_y)
   );

   always_ff @(posedge clk) begin
      if (enq) mem[tail] <= in_ent;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         vld_q <= 1'b0;
         res_q <= '0;
      end else begin
         if (enq) tail <= tail + 1'b1;
         if (pop) head <= head + 1'b1;
         unique case ({enq, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
         if (pop | byp) begin
            vld_q <= 1'b1;
            res_q <= alu_y;
         end else begin
            vld_q <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed and random checks of the
// station against a queue-based model of the issue rules.
module tb_reservation_station;
   import rsv_pkg::*;

   localparam int XLEN  = 32;
   localparam int DEPTH = 4;
`ifdef RSV_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;

   reservation_station_if #(.XLEN(XLEN)) bus ();

   reservation_station #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   rsv_entry_t      q[$];
   logic            exp_v   = 1'b0;
   logic [XLEN-1:0] exp_r   = '0;
   logic            exp_rdy = 1'b1;

   function automatic logic [XLEN-1:0] ref_alu(
      input logic [2:0] op,
      input logic [XLEN-1:0] a,
      input logic [XLEN-1:0] b
   );
      int s;
      s = int'(b % XLEN);
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return a ^ b;
         3'd5: return a << s;
         3'd6: return a >> s;
         default: return ($signed(a) < $signed(b)) ? 1 : 0;
      endcase
   endfunction

   task automatic model_reset();
      q.delete();
      exp_v   = 1'b0;
      exp_r   = '0;
      exp_rdy = 1'b1;
   endtask

   task automatic model_edge(
      input logic v,
      input logic [2:0] op,
      input logic [XLEN-1:0] a,
      input logic [XLEN-1:0] b
   );
      rsv_entry_t e;
      bit acc;
      acc   = v && (q.size() < DEPTH);
      exp_v = 1'b0;
`ifdef RSV_BYPASS_EN
      if (acc && q.size() == 0) begin
         exp_v = 1'b1;
         exp_r = ref_alu(op, a, b);
         acc   = 1'b0;
      end
`endif
      if (!exp_v && q.size() > 0) begin
         e     = q.pop_front();
         exp_v = 1'b1;
         exp_r = ref_alu(e.op, e.rs1, e.rs2);
      end
      if (acc) begin
         e.op  = rsv_op_e'(op);
         e.rs1 = a;
         e.rs2 = b;
         q.push_back(e);
      end
      exp_rdy = q.size() < DEPTH;
   endtask

   // drive one cycle, advance the model at the edge, land at edge+1
   task automatic cycle(
      input logic v,
      input logic [2:0] op,
      input logic [XLEN-1:0] a,
      input logic [XLEN-1:0] b
   );
      bus.valid_in = v;
      bus.rsv_type = op;
      bus.rs1      = a;
      bus.rs2      = b;
      @(posedge clk);
      if (rst) model_edge(v, op, a, b);
      #1;
   endtask

   task automatic test_reset();
      cycle(1'b0, 3'd0, '0, '0);
      model_reset();
      n_cmp++;
      if ({bus.valid_out, bus.result, bus.ready_out}
          !== {exp_v, exp_r, exp_rdy}) begin
         n_bad++;
         $display("FAIL reset_state got v=%0b r=%h rdy=%0b want v=%0b r=%h rdy=%0b",
                  bus.valid_out, bus.result, bus.ready_out,
                  exp_v, exp_r, exp_rdy);
      end
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 3'd0, '0, '0);
         n_cmp++;
         if ({bus.valid_out, bus.result, bus.ready_out}
             !== {1'b0, {XLEN{1'b0}}, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_idle[%0d] got v=%0b r=%h rdy=%0b want v=0 r=0 rdy=1",
                     i, bus.valid_out, bus.result, bus.ready_out);
         end
      end
   endtask

   task automatic test_single();
      int n;
      cycle(1'b1, 3'd0, 32'h0000_0005, 32'h0000_0007);
      n = 1;
      while (!bus.valid_out && n < 5) begin
         cycle(1'b0, 3'd0, '0, '0);
         n++;
      end
      n_cmp++;
      if (n !== LAT || bus.result !== 32'h0000_000C) begin
         n_bad++;
         $display("FAIL single_add got lat=%0d r=%h want lat=%0d r=0000000c",
                  n, bus.result, LAT);
      end
      cycle(1'b0, 3'd0, '0, '0);
      n_cmp++;
      if (bus.valid_out !== 1'b0 || bus.result !== 32'h0000_000C) begin
         n_bad++;
         $display("FAIL single_pulse got v=%0b r=%h want v=0 r=0000000c",
                  bus.valid_out, bus.result);
      end
   endtask

   task automatic test_corners();
      logic [2:0]      op  [5] = '{3'd0, 3'd1, 3'd7, 3'd6, 3'd5};
      logic [XLEN-1:0] a   [5] = '{32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF,
                                   32'h8000_0000, 32'h1};
      logic [XLEN-1:0] b   [5] = '{32'h1, 32'h1, 32'h1, 32'd31, 32'h21};
      logic [XLEN-1:0] want[5] = '{32'h0, 32'hFFFF_FFFF, 32'h1, 32'h1, 32'h2};
      int n;
      for (int k = 0; k < 5; k++) begin
         cycle(1'b1, op[k], a[k], b[k]);
         n = 1;
         while (!bus.valid_out && n < 5) begin
            cycle(1'b0, 3'd0, '0, '0);
            n++;
         end
         n_cmp++;
         if (!bus.valid_out || bus.result !== want[k]) begin
            n_bad++;
            $display("FAIL corner[%0d] got v=%0b r=%h want v=1 r=%h",
                     k, bus.valid_out, bus.result, want[k]);
         end
         cycle(1'b0, 3'd0, '0, '0);
      end
   endtask

   task automatic test_back_to_back();
      int pulses = 0;
      for (int i = 0; i < 8 + LAT; i++) begin
         if (i < 8)
            cycle(1'b1, 3'($urandom_range(2, 4)), $urandom, $urandom);
         else
            cycle(1'b0, 3'd0, '0, '0);
         if (bus.valid_out) pulses++;
         n_cmp++;
         if ({bus.valid_out, bus.result, bus.ready_out}
             !== {exp_v, exp_r, exp_rdy}) begin
            n_bad++;
            $display("FAIL b2b[%0d] got v=%0b r=%h rdy=%0b want v=%0b r=%h rdy=%0b",
                     i, bus.valid_out, bus.result, bus.ready_out,
                     exp_v, exp_r, exp_rdy);
         end
      end
      n_cmp++;
      if (pulses !== 8) begin
         n_bad++;
         $display("FAIL b2b_count got %0d want 8", pulses);
      end
   endtask

   task automatic test_reset_drop();
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 2; i++) begin
         cycle(1'b1, 3'd0, 32'h11, 32'h22);
         n_cmp++;
         if (bus.valid_out !== 1'b0 || bus.result !== '0) begin
            n_bad++;
            $display("FAIL rst_hold[%0d] got v=%0b r=%h want v=0 r=0",
                     i, bus.valid_out, bus.result);
         end
      end
      bus.valid_in = 1'b0;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 3'd0, '0, '0);
         n_cmp++;
         if ({bus.valid_out, bus.result, bus.ready_out}
             !== {exp_v, exp_r, exp_rdy}) begin
            n_bad++;
            $display("FAIL rst_drop[%0d] got v=%0b r=%h want v=%0b r=%h",
                     i, bus.valid_out, bus.result, exp_v, exp_r);
         end
      end
   endtask

   task automatic test_reset_mid();
      cycle(1'b1, 3'd0, 32'h1, 32'h2);
      cycle(1'b1, 3'd1, 32'h5, 32'h3);
      n_cmp++;
      if (bus.valid_out !== 1'b1 || bus.result !== exp_r) begin
         n_bad++;
         $display("FAIL mid_pre got v=%0b r=%h want v=1 r=%h",
                  bus.valid_out, bus.result, exp_r);
      end
      bus.valid_in = 1'b0;
      #2 rst = 1'b0;
      #1;
      model_reset();
      n_cmp++;
      if ({bus.valid_out, bus.result, bus.ready_out}
          !== {1'b0, {XLEN{1'b0}}, 1'b1}) begin
         n_bad++;
         $display("FAIL mid_async got v=%0b r=%h rdy=%0b want v=0 r=0 rdy=1",
                  bus.valid_out, bus.result, bus.ready_out);
      end
      @(posedge clk);
      #1 rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 3'd0, '0, '0);
         n_cmp++;
         if (bus.valid_out !== 1'b0 || bus.result !== '0) begin
            n_bad++;
            $display("FAIL mid_after[%0d] got v=%0b r=%h want v=0 r=0",
                     i, bus.valid_out, bus.result);
         end
      end
   endtask

   task automatic test_bypass();
      int n;
      cycle(1'b1, 3'd4, 32'hF0F0_F0F0, 32'hFFFF_0000);
      n = 1;
      while (!bus.valid_out && n < 5) begin
         cycle(1'b0, 3'd0, '0, '0);
         n++;
      end
      n_cmp++;
      if (n !== LAT || bus.result !== 32'h0F0F_F0F0) begin
         n_bad++;
         $display("FAIL bypass_xor got lat=%0d r=%h want lat=%0d r=0f0ff0f0",
                  n, bus.result, LAT);
      end
      cycle(1'b0, 3'd0, '0, '0);
   endtask

   function automatic logic [XLEN-1:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         cycle(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
               pick(), pick());
         n_cmp++;
         if ({bus.valid_out, bus.result, bus.ready_out}
             !== {exp_v, exp_r, exp_rdy}) begin
            n_bad++;
            $display("FAIL random[%0d] got v=%0b r=%h rdy=%0b want v=%0b r=%h rdy=%0b",
                     i, bus.valid_out, bus.result, bus.ready_out,
                     exp_v, exp_r, exp_rdy);
         end
      end
   endtask

   initial begin
      bus.valid_in = 1'b0;
      bus.rsv_type = '0;
      bus.rs1      = '0;
      bus.rs2      = '0;
      @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_corners();
      test_back_to_back();
      test_reset_drop();
      test_reset_mid();
      test_bypass();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- In-order reservation station plus a single-cycle integer execute unit, sitting between rename/dispatch and the writeback bus in the OoO engine.
- Accepts one operation per cycle (type code plus two XLEN-bit operand values) into a small FIFO-ordered entry array.
- Issues the oldest entry each cycle and presents a registered result with a valid strobe.

Parameters:
- XLEN, 32, operand/result width in bits (power of two, >= 8)
- DEPTH, 4, number of entries (power of two, >= 2)

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- valid_in  input  1  dispatch request this cycle
- rsv_type  input  3  operation select
- rs1  input  XLEN  operand A value
- rs2  input  XLEN  operand B value
- ready_out  output  1  entry available; a dispatch is accepted only when valid_in & ready_out
- valid_out  output  1  result valid this cycle (single-cycle pulse per operation)
- result  output  XLEN  computed result, meaningful only when valid_out=1

Behaviour:
- Reset (rst=0, asynchronous): entry count=0, head/tail pointers=0, valid_out=0, result=0, ready_out=1. All entry valid bits cleared. Reset asserted mid-operation discards all queued entries and any pending result.
- Entry holds rsv_type, rs1, rs2; storage is a circular buffer with head (oldest) and tail pointers of log2(DEPTH) bits that wrap modulo DEPTH.
- Accept: on an edge with valid_in=1 and ready_out=1, write the entry at tail, tail+1.
- valid_in=1 with ready_out=0: request is dropped; no state change; the sender must hold it.
- ready_out = (count < DEPTH), derived from registered count; it does not anticipate a same-cycle pop.
- Issue: on every edge where count>0 (evaluated before that edge's push), pop the head entry, compute, and register result; valid_out=1 for the following cycle.
- Otherwise, on that edge: valid_out=0 and result holds its previous value.
- Latency: an operation accepted at edge N into an empty station appears on valid_out/result after edge N+1. Throughput is one operation per cycle.
- Simultaneous push and pop: both occur; count unchanged.
- Push into a full station never occurs (ready_out=0).
- Strict in-order issue; results leave in acceptance order.
- Operations by rsv_type, all modulo 2^XLEN:
  - 0 ADD: rs1+rs2
  - 1 SUB: rs1-rs2
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SLL: rs1 << rs2[log2(XLEN)-1:0]
  - 6 SRL: logical
  - 7 SLT: signed rs1<rs2 gives 1, else 0, zero-extended
- Upper bits of rs2 are ignored for shifts; no exceptions or flags.

Optional Feature:
- Macro: RSV_BYPASS_EN.
- Defined: when count=0 and a dispatch is accepted, the entry skips storage. Its result is registered at the same edge, giving valid_out after edge N (latency 1). The count is not incremented. If count>0, normal queued order is preserved: no bypass.
- Undefined: every operation passes through the entry array (latency 2 from an empty station).

Decomposition:
- Shared package rsv_pkg:
  - 3-bit operation enum (RSV_ADD..RSV_SLT)
  - entry struct type (type, rs1, rs2)
  - default XLEN/DEPTH constants
- One natural sub-module: rsv_alu. It is purely combinational (op, a, b -> y) and instantiated once at the queue head.

Test Plan:
- Reset check: after rst=0 then release with valid_in=0 -> valid_out=0, result=0, ready_out=1; no valid_out for 10 idle cycles.
- Single op: ADD rs1=0x0000_0005, rs2=0x0000_0007 accepted at edge N -> valid_out=1, result=0x0000_000C after edge N+1, then valid_out=0.
- Wrap and signed: ADD 0xFFFF_FFFF+1 -> 0x0000_0000. SUB 0-1 -> 0xFFFF_FFFF. SLT 0xFFFF_FFFF vs 1 -> 1. SRL 0x8000_0000 by 31 -> 1. SLL 1 by rs2=0x21 -> 0x2 (shamt 1).
- Back-to-back: 8 consecutive ops (AND/OR/XOR mix) -> 8 consecutive valid_out cycles, results in acceptance order; pointer wrap exercised.
- Full/backpressure: stall issue is not possible, so push DEPTH+1 ops with bypass off while checking ready_out stays 1 (simultaneous push/pop keeps count<=1). Drive valid_in for an op while asserting reset -> op dropped; reset mid-stream clears valid_out immediately (asynchronous).
- Bypass build (RSV_BYPASS_EN): XOR 0xF0F0_F0F0, 0xFFFF_0000 accepted at edge N -> result 0x0F0F_F0F0 valid after edge N.
